ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Two-requester arbiter and sequencer for the processor's single-port 16-bit data RAM.
- Port A is instruction fetch; port B is load/store. Both ports may read or write.
- Serialises accesses with round-robin priority and drives the RAM's address, data_in, re and we pins.
- Captures read data and returns a one-cycle ack per completed transaction.

Parameters:
- ADDR_WIDTH, 16, width of requester and RAM address buses.
- DATA_WIDTH, 16, width of read and write data buses.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous reset, active-high.
- req_a  input  1  port A request; held high until ack_a is sampled.
- we_a  input  1  port A write (1) or read (0); stable while req_a is high.
- addr_a  input  ADDR_WIDTH  port A address; stable while req_a is high.
- wdata_a  input  DATA_WIDTH  port A write data.
- ack_a  output  1  one-cycle completion pulse for port A.
- rdata_a  output  DATA_WIDTH  port A read data; valid with ack_a and held until A's next read completes.
- req_b, we_b, addr_b, wdata_b, ack_b, rdata_b: same as port A, for port B.
- mem_addr  output  ADDR_WIDTH  to RAM address.
- mem_wdata  output  DATA_WIDTH  to RAM data_in.
- mem_re  output  1  to RAM re.
- mem_we  output  1  to RAM we.
- mem_rdata  input  DATA_WIDTH  from RAM data_out; high-Z when mem_re=0.
- busy  output  1  high in the ACCESS and DONE states.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, priority pointer=A. All outputs 0: ack_a, ack_b, rdata_a, rdata_b, mem_addr, mem_wdata, mem_re, mem_we, busy.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - On a clock edge with req_a or req_b high, select the owner and go to ACCESS.
  - Owner selection: if only one port requests, grant it. If both request, grant the port named by the priority pointer.
  - On the same edge, latch the owner's addr into mem_addr and wdata into mem_wdata. Set mem_we=we_x and mem_re=~we_x.
  - With no request, stay in IDLE.
- ACCESS:
  - Lasts exactly one cycle. mem_addr, mem_wdata, mem_re and mem_we are stable for the whole cycle.
  - At the closing edge, the RAM commits the write if mem_we=1.
  - For a read, the arbiter captures mem_rdata into the owner's rdata register on the same edge.
  - At that edge, clear mem_re/mem_we to 0 and go to DONE.
- DONE:
  - Lasts one cycle. The owner's ack is high for this cycle only.
  - At the closing edge, set the priority pointer to the non-owner port and go to IDLE.
- mem_addr and mem_wdata hold their last values outside ACCESS. mem_re and mem_we are 0 in IDLE and DONE.
- The non-owner's rdata is never modified. A write never modifies rdata_x.
- Latency: req sampled high at edge N means ACCESS runs from edge N to N+1 and ack is high from edge N+1 to N+2. That is 2 cycles from sampling to ack, with ack in the second cycle.
- Requester protocol: drop req on the edge where ack is sampled. If req stays high, it is sampled at the following IDLE edge as a new transaction.
- Throughput: maximum one transaction per 3 cycles (IDLE, ACCESS, DONE).
- Fairness: with both ports requesting continuously, grants strictly alternate. A waiting port is granted within one transaction of the other port.
- Request changes during ACCESS or DONE (req, we, addr, wdata) are ignored. Only values latched in IDLE are used.
- Reset during ACCESS:
  - A write already presented for that cycle may commit at the reset edge.
  - No ack is issued and the owner's rdata is cleared to 0.
  - The FSM returns to IDLE with the pointer at A.
- Reset during DONE: ack is cleared on the reset edge and the completion is lost to the requester.
- Addresses pass through unmodified. Range checking against RAM depth is the requester's responsibility.
- Write-then-read to the same address by different ports returns the newly written data, because accesses are serialised.

Test Plan:
- Reset: hold reset 2 cycles with req_a=req_b=1 -> all outputs 0, no ack, busy=0. After release, A is granted first.
- Single read: preload mem[5]=16'hBEEF, pulse req_a (we_a=0, addr_a=5) -> mem_re=1 for exactly one cycle with mem_addr=5. ack_a pulses 2 cycles after req is sampled, rdata_a=16'hBEEF, rdata_b unchanged.
- Write then read: B writes 16'h1234 to addr 3, then A reads addr 3 -> mem_we=1 for one cycle with mem_wdata=16'h1234. A's later read returns rdata_a=16'h1234.
- Simultaneous requests: req_a and req_b rise together from reset, both held for 4 transactions -> grant order A, B, A, B. Each ack is a single-cycle pulse, 3 cycles apart.
- Mid-transaction changes: change addr_a from 7 to 9 during ACCESS -> mem_addr stays 7 and the read returns mem[7].
- Reset in ACCESS: assert reset during a port B read -> no ack_b, rdata_b=0, state IDLE. The next simultaneous request grants A.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Bundle of the two requester ports and the single-port RAM pins around ram_arbiter.
// The slave modport is the arbiter; the master modport is its environment (requesters plus RAM).
interface ram_arbiter_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16
);
   logic                  req_a;
   logic                  we_a;
   logic [ADDR_WIDTH-1:0] addr_a;
   logic [DATA_WIDTH-1:0] wdata_a;
   logic                  ack_a;
   logic [DATA_WIDTH-1:0] rdata_a;

   logic                  req_b;
   logic                  we_b;
   logic [ADDR_WIDTH-1:0] addr_b;
   logic [DATA_WIDTH-1:0] wdata_b;
   logic                  ack_b;
   logic [DATA_WIDTH-1:0] rdata_b;

   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  mem_re;
   logic                  mem_we;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  busy;

   modport slave (
      input  req_a, we_a, addr_a, wdata_a,
      output ack_a, rdata_a,
      input  req_b, we_b, addr_b, wdata_b,
      output ack_b, rdata_b,
      output mem_addr, mem_wdata, mem_re, mem_we,
      input  mem_rdata,
      output busy
   );

   modport master (
      output req_a, we_a, addr_a, wdata_a,
      input  ack_a, rdata_a,
      output req_b, we_b, addr_b, wdata_b,
      input  ack_b, rdata_b,
      input  mem_addr, mem_wdata, mem_re, mem_we,
      output mem_rdata,
      input  busy
   );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port data RAM between
// instruction fetch (port A) and load/store (port B); one access per IDLE/ACCESS/DONE pass.
module ram_arbiter #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16
) (
   input logic          clk,
   input logic          reset,
   ram_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   typedef enum logic {PORT_A, PORT_B} port_t;

   state_t state, state_next;
   port_t  owner, ptr, grant;
   logic   start;

   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  mem_re, mem_we;
   logic                  ack_a, ack_b;
   logic [DATA_WIDTH-1:0] rdata_a, rdata_b;

   always_comb begin
      state_next = state;
      grant      = PORT_A;
      start      = 1'b0;
      case (state)
         IDLE: begin
            if (bus.req_a || bus.req_b) begin
               start      = 1'b1;
               state_next = ACCESS;
               if (bus.req_a && bus.req_b) grant = ptr;
               else if (bus.req_b)         grant = PORT_B;
               else                        grant = PORT_A;
            end
         end
         ACCESS:  state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         owner     <= PORT_A;
         ptr       <= PORT_A;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_re    <= 1'b0;
         mem_we    <= 1'b0;
         ack_a     <= 1'b0;
         ack_b     <= 1'b0;
         rdata_a   <= '0;
         rdata_b   <= '0;
      end else begin
         state <= state_next;
         ack_a <= 1'b0;
         ack_b <= 1'b0;

         // Request fields are sampled only here; later changes on the bus are ignored.
         if (start) begin
            owner <= grant;
            if (grant == PORT_B) begin
               mem_addr  <= bus.addr_b;
               mem_wdata <= bus.wdata_b;
               mem_we    <= bus.we_b;
               mem_re    <= ~bus.we_b;
            end else begin
               mem_addr  <= bus.addr_a;
               mem_wdata <= bus.wdata_a;
               mem_we    <= bus.we_a;
               mem_re    <= ~bus.we_a;
            end
         end

         if (state == ACCESS) begin
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            if (mem_re) begin
               if (owner == PORT_B) rdata_b <= bus.mem_rdata;
               else                 rdata_a <= bus.mem_rdata;
            end
            ack_a <= (owner == PORT_A);
            ack_b <= (owner == PORT_B);
         end

         if (state == DONE) ptr <= (owner == PORT_A) ? PORT_B : PORT_A;
      end
   end

   assign bus.mem_addr  = mem_addr;
   assign bus.mem_wdata = mem_wdata;
   assign bus.mem_re    = mem_re;
   assign bus.mem_we    = mem_we;
   assign bus.ack_a     = ack_a;
   assign bus.ack_b     = ack_b;
   assign bus.rdata_a   = rdata_a;
   assign bus.rdata_b   = rdata_b;
   assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a table of single transactions plus hand-written
// sequences for reset, back-to-back contention, mid-access changes and reset in ACCESS.
module tb_ram_arbiter;
   logic clk = 1'b0;
   logic reset;
   logic mem_init;

   always #5 clk = ~clk;

   ram_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

   ram_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Small RAM model; read data is a recognisable junk value when re is low.
   logic [15:0] mem [16];
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 16; i++) mem[i] <= 16'h0000;
         mem[5] <= 16'hBEEF;
         mem[7] <= 16'h0777;
         mem[9] <= 16'h0999;
      end else if (bus.mem_we) begin
         mem[bus.mem_addr[3:0]] <= bus.mem_wdata;
      end
   end
   assign bus.mem_rdata = bus.mem_re ? mem[bus.mem_addr[3:0]] : 16'hDEAD;

   int passed = 0;
   int total  = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   typedef struct {
      logic        req_a;
      logic        we_a;
      logic [15:0] addr_a;
      logic [15:0] wdata_a;
      logic        req_b;
      logic        we_b;
      logic [15:0] addr_b;
      logic [15:0] wdata_b;
      logic [15:0] exp_addr;
      logic [15:0] exp_wdata;
      logic        exp_re;
      logic        exp_we;
      logic        exp_ack_a;
      logic        exp_ack_b;
      logic [15:0] exp_rdata_a;
      logic [15:0] exp_rdata_b;
   } vec_t;

   vec_t vecs [8];

   task automatic drop_reqs();
      bus.req_a = 1'b0;
      bus.req_b = 1'b0;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      bus.req_a = v.req_a;  bus.we_a = v.we_a;  bus.addr_a = v.addr_a;  bus.wdata_a = v.wdata_a;
      bus.req_b = v.req_b;  bus.we_b = v.we_b;  bus.addr_b = v.addr_b;  bus.wdata_b = v.wdata_b;
      @(negedge clk);
      chk($sformatf("v%0d access addr", idx), 128'(bus.mem_addr), 128'(v.exp_addr));
      chk($sformatf("v%0d access wdata", idx), 128'(bus.mem_wdata), 128'(v.exp_wdata));
      chk($sformatf("v%0d access re/we/busy/ack", idx),
          128'({bus.mem_re, bus.mem_we, bus.busy, bus.ack_a, bus.ack_b}),
          128'({v.exp_re, v.exp_we, 1'b1, 1'b0, 1'b0}));
      drop_reqs();
      @(negedge clk);
      chk($sformatf("v%0d done ack/re/we/busy", idx),
          128'({bus.ack_a, bus.ack_b, bus.mem_re, bus.mem_we, bus.busy}),
          128'({v.exp_ack_a, v.exp_ack_b, 1'b0, 1'b0, 1'b1}));
      chk($sformatf("v%0d rdata_a", idx), 128'(bus.rdata_a), 128'(v.exp_rdata_a));
      chk($sformatf("v%0d rdata_b", idx), 128'(bus.rdata_b), 128'(v.exp_rdata_b));
      @(negedge clk);
      chk($sformatf("v%0d idle ack/busy", idx),
          128'({bus.ack_a, bus.ack_b, bus.busy}), 128'(3'b000));
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      drop_reqs();
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //                 reqA weA addrA   wdataA   reqB weB addrB   wdataB   addr     wdata    re   we   ackA ackB rdataA   rdataB
      vecs[0] = '{1'b1, 1'b0, 16'd5, 16'h1111, 1'b0, 1'b0, 16'd0, 16'h0000, 16'd5, 16'h1111, 1'b1, 1'b0, 1'b1, 1'b0, 16'hBEEF, 16'h0000};
      vecs[1] = '{1'b0, 1'b0, 16'd0, 16'h0000, 1'b1, 1'b1, 16'd3, 16'h1234, 16'd3, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b1, 16'hBEEF, 16'h0000};
      vecs[2] = '{1'b1, 1'b0, 16'd3, 16'h2222, 1'b0, 1'b0, 16'd0, 16'h0000, 16'd3, 16'h2222, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1234, 16'h0000};
      vecs[3] = '{1'b1, 1'b0, 16'd7, 16'h3333, 1'b1, 1'b0, 16'd9, 16'h4444, 16'd9, 16'h4444, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h0999};
      vecs[4] = '{1'b1, 1'b0, 16'd9, 16'h5151, 1'b1, 1'b1, 16'd5, 16'h5555, 16'd9, 16'h5151, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0999, 16'h0999};
      vecs[5] = '{1'b1, 1'b1, 16'd9, 16'hAAAA, 1'b0, 1'b0, 16'd0, 16'h0000, 16'd9, 16'hAAAA, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0999, 16'h0999};
      vecs[6] = '{1'b0, 1'b0, 16'd0, 16'h0000, 1'b1, 1'b0, 16'd9, 16'h6666, 16'd9, 16'h6666, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0999, 16'hAAAA};
      vecs[7] = '{1'b1, 1'b0, 16'd5, 16'h7777, 1'b1, 1'b0, 16'd3, 16'h8888, 16'd5, 16'h7777, 1'b1, 1'b0, 1'b1, 1'b0, 16'hBEEF, 16'hAAAA};

      // Reset held two cycles with both ports requesting.
      reset = 1'b1;  mem_init = 1'b1;
      bus.req_a = 1'b1;  bus.we_a = 1'b0;  bus.addr_a = 16'd5;  bus.wdata_a = 16'h0000;
      bus.req_b = 1'b1;  bus.we_b = 1'b0;  bus.addr_b = 16'd9;  bus.wdata_b = 16'h0000;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk($sformatf("reset outputs c%0d", c),
             128'({bus.ack_a, bus.ack_b, bus.mem_re, bus.mem_we, bus.busy,
                   bus.rdata_a, bus.rdata_b, bus.mem_addr, bus.mem_wdata}), 128'(0));
      end
      reset = 1'b0;  mem_init = 1'b0;
      @(negedge clk);
      chk("post-reset grant A addr", 128'(bus.mem_addr), 128'(16'd5));
      chk("post-reset grant A re", 128'(bus.mem_re), 128'(1'b1));
      drop_reqs();
      @(negedge clk);
      chk("post-reset ack a/b", 128'({bus.ack_a, bus.ack_b}), 128'(2'b10));
      @(negedge clk);
      pulse_reset();

      for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

      // Continuous contention: grants alternate A,B,A,B, acks 3 cycles apart.
      pulse_reset();
      bus.req_a = 1'b1;  bus.we_a = 1'b0;  bus.addr_a = 16'd5;
      bus.req_b = 1'b1;  bus.we_b = 1'b0;  bus.addr_b = 16'd9;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         chk($sformatf("contention acks c%0d", c), 128'({bus.ack_a, bus.ack_b}),
             128'({(c == 2 || c == 8), (c == 5 || c == 11)}));
      end
      drop_reqs();
      chk("contention rdata_a", 128'(bus.rdata_a), 128'(16'hBEEF));
      chk("contention rdata_b", 128'(bus.rdata_b), 128'(16'hAAAA));
      @(negedge clk);

      // Address change during ACCESS must not affect the access.
      bus.req_a = 1'b1;  bus.we_a = 1'b0;  bus.addr_a = 16'd7;
      @(negedge clk);
      bus.addr_a = 16'd9;
      #1;
      chk("midchange mem_addr", 128'(bus.mem_addr), 128'(16'd7));
      @(negedge clk);
      chk("midchange ack_a", 128'(bus.ack_a), 128'(1'b1));
      chk("midchange rdata_a", 128'(bus.rdata_a), 128'(16'h0777));
      drop_reqs();
      @(negedge clk);

      // Reset while port B's read is in ACCESS.
      bus.req_b = 1'b1;  bus.we_b = 1'b0;  bus.addr_b = 16'd9;
      @(negedge clk);
      chk("rst-access re/addr", 128'({bus.mem_re, bus.mem_addr}), 128'({1'b1, 16'd9}));
      reset = 1'b1;
      drop_reqs();
      @(negedge clk);
      chk("rst-access ack_b/busy/re", 128'({bus.ack_b, bus.busy, bus.mem_re}), 128'(3'b000));
      chk("rst-access rdata_b", 128'(bus.rdata_b), 128'(16'h0000));
      reset = 1'b0;
      @(negedge clk);
      chk("rst-access no late ack", 128'({bus.ack_a, bus.ack_b}), 128'(2'b00));
      bus.req_a = 1'b1;  bus.addr_a = 16'd7;
      bus.req_b = 1'b1;  bus.addr_b = 16'd9;
      @(negedge clk);
      chk("rst-access next grant A", 128'(bus.mem_addr), 128'(16'd7));
      drop_reqs();
      @(negedge clk);
      chk("rst-access next ack", 128'({bus.ack_a, bus.ack_b}), 128'(2'b10));
      @(negedge clk);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
